// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared default widths for AXI-Stream blocks
package common_pkg;
  localparam int DEFAULT_TDATA_W = 32;
  localparam int DEFAULT_TID_W   = 4;
  localparam int DEFAULT_TDEST_W = 4;
endpackage

// File: rtl/axis_if.sv
// rtl/axis_if.sv - AXI-Stream interface with receiver/transmitter modports
interface axis_if
  import common_pkg::*;
#(
  parameter int TDATA_W = DEFAULT_TDATA_W,
  parameter int TID_W   = DEFAULT_TID_W,
  parameter int TDEST_W = DEFAULT_TDEST_W
) (
  input logic aclk,
  input logic arst_n
);
  localparam int TSTRB_W = TDATA_W / 8;
  localparam int TKEEP_W = TDATA_W / 8;

  logic [TDATA_W-1:0] tdata;
  logic [TSTRB_W-1:0] tstrb;
  logic [TKEEP_W-1:0] tkeep;
  logic               tlast;
  logic [TID_W-1:0]   tid;
  logic [TDEST_W-1:0] tdest;
  logic               twakeup;
  logic               tvalid;
  logic               tready;

  modport transmitter (
    input  aclk, arst_n, tready,
    output tdata, tstrb, tkeep, tlast, tid, tdest, twakeup, tvalid
  );

  modport receiver (
    input  aclk, arst_n, tdata, tstrb, tkeep, tlast, tid, tdest, twakeup, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_proto_monitor.sv
// rtl/axis_proto_monitor.sv - sticky receiver-side handshake violation checker
module axis_proto_monitor #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic                 i_ready,
  input  logic [PAYLOAD_W-1:0] i_payload,
  output logic                 o_err_valid_drop,
  output logic                 o_err_payload_change
);
  logic                 r_stalled;
  logic [PAYLOAD_W-1:0] r_payload;
  logic                 r_err_valid_drop;
  logic                 r_err_payload_change;

  // Remember a stall and flag a dropped or altered offer on the following edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stalled            <= 1'b0;
      r_err_valid_drop     <= 1'b0;
      r_err_payload_change <= 1'b0;
    end else begin
      r_stalled <= i_valid & ~i_ready;
      if (r_stalled && !i_valid) begin
        r_err_valid_drop <= 1'b1;
      end
      if (r_stalled && i_valid && (i_payload != r_payload)) begin
        r_err_payload_change <= 1'b1;
      end
    end
  end

  // Payload snapshot is only consulted when r_stalled is set, so it needs no reset.
  always_ff @(posedge i_clk) begin
    r_payload <= i_payload;
  end

  assign o_err_valid_drop     = r_err_valid_drop;
  assign o_err_payload_change = r_err_payload_change;
endmodule

// File: rtl/axis_modport_slice.sv
// rtl/axis_modport_slice.sv - two-entry AXI-Stream skid slice with protocol monitor
module axis_modport_slice
  import common_pkg::*;
#(
  parameter int TDATA_W = DEFAULT_TDATA_W,
  parameter int TID_W   = DEFAULT_TID_W,
  parameter int TDEST_W = DEFAULT_TDEST_W
) (
  input  logic        aclk,
  input  logic        arst_n,
  axis_if.receiver    s_axis,
  axis_if.transmitter m_axis,
  output logic        err_valid_drop,
  output logic        err_payload_change
);
  localparam int TSTRB_W = TDATA_W / 8;
  localparam int TKEEP_W = TDATA_W / 8;

  if (TDATA_W <= 0 || (TDATA_W % 8) != 0 || TID_W <= 0 || TDEST_W <= 0) begin : g_bad_params
    $error("axis_modport_slice: illegal width parameters");
  end

  typedef struct packed {
    logic [TDATA_W-1:0] tdata;
    logic [TSTRB_W-1:0] tstrb;
    logic [TKEEP_W-1:0] tkeep;
    logic               tlast;
    logic [TID_W-1:0]   tid;
    logic [TDEST_W-1:0] tdest;
    logic               twakeup;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  beat_t w_s_beat;
  beat_t r_main;
  beat_t r_skid;
  logic  r_m_tvalid;
  logic  r_skid_valid;
  logic  r_s_tready;
  logic  w_s_fire;
  logic  w_m_fire;
  logic  w_load_main_skid;
  logic  w_load_main_s;
  logic  w_load_skid;
  logic  w_m_tvalid_nxt;
  logic  w_skid_valid_nxt;

  assign w_s_beat.tdata   = s_axis.tdata;
  assign w_s_beat.tstrb   = s_axis.tstrb;
  assign w_s_beat.tkeep   = s_axis.tkeep;
  assign w_s_beat.tlast   = s_axis.tlast;
  assign w_s_beat.tid     = s_axis.tid;
  assign w_s_beat.tdest   = s_axis.tdest;
  assign w_s_beat.twakeup = s_axis.twakeup;

  assign w_s_fire = s_axis.tvalid & r_s_tready;
  assign w_m_fire = r_m_tvalid & m_axis.tready;

  // Decide where each beat goes: the skid always drains into main before new input does.
  always_comb begin
    w_load_main_skid = 1'b0;
    w_load_main_s    = 1'b0;
    w_load_skid      = 1'b0;
    w_m_tvalid_nxt   = r_m_tvalid;
    w_skid_valid_nxt = r_skid_valid;
    if (!r_m_tvalid || w_m_fire) begin
      if (r_skid_valid) begin
        w_load_main_skid = 1'b1;
        w_skid_valid_nxt = 1'b0;
        w_m_tvalid_nxt   = 1'b1;
      end else if (w_s_fire) begin
        w_load_main_s  = 1'b1;
        w_m_tvalid_nxt = 1'b1;
      end else begin
        w_m_tvalid_nxt = 1'b0;
      end
    end else if (w_s_fire) begin
      w_load_skid      = 1'b1;
      w_skid_valid_nxt = 1'b1;
    end
  end

  // Occupancy flags and the registered upstream ready.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      r_m_tvalid   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_s_tready   <= 1'b0;
    end else begin
      r_m_tvalid   <= w_m_tvalid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_s_tready   <= ~w_skid_valid_nxt;
    end
  end

  // Payload registers; qualified by the valid flags, so left without reset.
  always_ff @(posedge aclk) begin
    if (w_load_main_skid) begin
      r_main <= r_skid;
    end else if (w_load_main_s) begin
      r_main <= w_s_beat;
    end
    if (w_load_skid) begin
      r_skid <= w_s_beat;
    end
  end

  assign s_axis.tready  = r_s_tready;
  assign m_axis.tvalid  = r_m_tvalid;
  assign m_axis.tdata   = r_main.tdata;
  assign m_axis.tstrb   = r_main.tstrb;
  assign m_axis.tkeep   = r_main.tkeep;
  assign m_axis.tlast   = r_main.tlast;
  assign m_axis.tid     = r_main.tid;
  assign m_axis.tdest   = r_main.tdest;
  assign m_axis.twakeup = r_main.twakeup;

  axis_proto_monitor #(
    .PAYLOAD_W(BEAT_W)
  ) u_monitor (
    .i_clk               (aclk),
    .i_rst_n             (arst_n),
    .i_valid             (s_axis.tvalid),
    .i_ready             (r_s_tready),
    .i_payload           (w_s_beat),
    .o_err_valid_drop    (err_valid_drop),
    .o_err_payload_change(err_payload_change)
  );
endmodule

// File: tb/tb_axis_modport_slice.sv
// tb/tb_axis_modport_slice.sv - randomized scoreboard bench for axis_modport_slice
module tb_axis_modport_slice;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int DSTW = 3;
  localparam int BW = DW + DW/8 + DW/8 + 1 + IW + DSTW + 1;

  logic clk;
  logic arst_n;
  logic err_valid_drop;
  logic err_payload_change;

  axis_if #(.TDATA_W(DW), .TID_W(IW), .TDEST_W(DSTW)) s_if (.aclk(clk), .arst_n(arst_n));
  axis_if #(.TDATA_W(DW), .TID_W(IW), .TDEST_W(DSTW)) m_if (.aclk(clk), .arst_n(arst_n));

  axis_modport_slice #(.TDATA_W(DW), .TID_W(IW), .TDEST_W(DSTW)) dut (
    .aclk              (clk),
    .arst_n            (arst_n),
    .s_axis            (s_if),
    .m_axis            (m_if),
    .err_valid_drop    (err_valid_drop),
    .err_payload_change(err_payload_change)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [BW-1:0] s_beat();
    return {s_if.tdata, s_if.tstrb, s_if.tkeep, s_if.tlast, s_if.tid, s_if.tdest, s_if.twakeup};
  endfunction

  function automatic logic [BW-1:0] m_beat();
    return {m_if.tdata, m_if.tstrb, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest, m_if.twakeup};
  endfunction

  // Reference model: a plain FIFO of accepted beats, capacity two, plus monitor flags.
  logic [BW-1:0] q[$];
  logic [DW-1:0] out_log[$];
  int            n_out = 0;
  bit            md_edge_seen = 0;
  bit            md_stalled = 0;
  bit            md_drop = 0;
  bit            md_chg = 0;
  logic [BW-1:0] md_prev;

  always @(negedge clk) begin
    bit exp_rdy, sf, mf;
    if (!arst_n) begin
      q.delete();
      md_edge_seen = 0;
      md_stalled = 0;
      md_drop = 0;
      md_chg = 0;
      check("rst_m_tvalid", m_if.tvalid, 0);
      check("rst_s_tready", s_if.tready, 0);
      check("rst_err_drop", err_valid_drop, 0);
      check("rst_err_chg", err_payload_change, 0);
    end else begin
      exp_rdy = md_edge_seen && (q.size() < 2);
      check("s_tready", s_if.tready, exp_rdy);
      check("m_tvalid", m_if.tvalid, q.size() > 0);
      if (q.size() > 0) check("m_beat", m_beat(), q[0]);
      check("err_valid_drop", err_valid_drop, md_drop);
      check("err_payload_change", err_payload_change, md_chg);
      sf = s_if.tvalid && exp_rdy;
      mf = (q.size() > 0) && m_if.tready;
      if (mf) begin
        out_log.push_back(m_if.tdata);
        void'(q.pop_front());
        n_out++;
      end
      if (md_stalled && !s_if.tvalid) md_drop = 1;
      if (md_stalled && s_if.tvalid && s_beat() != md_prev) md_chg = 1;
      md_stalled = s_if.tvalid && !exp_rdy;
      md_prev = s_beat();
      if (sf) q.push_back(s_beat());
      md_edge_seen = 1;
    end
  end

  task automatic set_beat(input logic [31:0] d);
    s_if.tdata   = d;
    s_if.tstrb   = d[3:0];
    s_if.tkeep   = ~d[7:4];
    s_if.tlast   = d[0];
    s_if.tid     = d[11:8];
    s_if.tdest   = d[14:12];
    s_if.twakeup = d[1];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] d, input int max_cyc, output int cyc, output bit acc);
    set_beat(d);
    s_if.tvalid = 1;
    cyc = 0;
    acc = 0;
    while (!acc && cyc < max_cyc) begin
      @(negedge clk);
      acc = s_if.tready;
      tick();
      cyc++;
    end
  endtask

  task automatic do_reset();
    arst_n = 0;
    s_if.tvalid = 0;
    #1;
    tick();
    arst_n = 1;
  endtask

  initial begin
    int  cyc, tot, n0, sent;
    bit  acc;
    clk = 0;
    arst_n = 0;
    s_if.tvalid = 0;
    set_beat(0);
    m_if.tready = 0;
    #1;
    check("init_m_tvalid", m_if.tvalid, 0);
    check("init_s_tready", s_if.tready, 0);
    repeat (2) tick();
    arst_n = 1;
    m_if.tready = 1;
    check("release_s_tready_still_low", s_if.tready, 0);

    // Stream 0x01..0x10 at full rate.
    tot = 0;
    n0 = n_out;
    for (int k = 1; k <= 16; k++) begin
      offer(k, 10, cyc, acc);
      check("stream_accept", acc, 1);
      tot += cyc;
    end
    s_if.tvalid = 0;
    check("stream_cycles", tot, 17);
    tick();
    check("stream_out_count", n_out - n0, 16);

    // Downstream stall: two beats fit, the third waits upstream.
    out_log.delete();
    m_if.tready = 0;
    offer(32'hA0, 4, cyc, acc);
    check("stall_acc_a0", acc, 1);
    offer(32'hA1, 4, cyc, acc);
    check("stall_acc_a1", acc, 1);
    check("stall_s_tready_low", s_if.tready, 0);
    offer(32'hA2, 4, cyc, acc);
    check("stall_a2_held", acc, 0);

    // Release the stall and confirm FIFO order.
    m_if.tready = 1;
    offer(32'hA2, 10, cyc, acc);
    check("release_acc_a2", acc, 1);
    s_if.tvalid = 0;
    repeat (3) tick();
    check("order_count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      check("order_0", out_log[0], 32'hA0);
      check("order_1", out_log[1], 32'hA1);
      check("order_2", out_log[2], 32'hA2);
    end

    // Randomized traffic with random backpressure.
    n0 = n_out;
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      if (!s_if.tvalid && $urandom_range(0, 9) < 6) begin
        set_beat($urandom);
        s_if.tvalid = 1;
      end
      m_if.tready = $urandom_range(0, 1);
      @(negedge clk);
      acc = s_if.tvalid && s_if.tready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        s_if.tvalid = 0;
      end
    end
    check("rand_sent", sent, 1000);
    m_if.tready = 1;
    repeat (4) tick();
    check("rand_out_count", n_out - n0, 1000);
    check("rand_no_drop", err_valid_drop, 0);
    check("rand_no_chg", err_payload_change, 0);

    // Upstream drops tvalid while stalled.
    m_if.tready = 0;
    do_reset();
    offer(32'h11, 5, cyc, acc);
    offer(32'h12, 5, cyc, acc);
    set_beat(32'h55);
    s_if.tvalid = 1;
    tick();
    s_if.tvalid = 0;
    tick();
    check("drop_flag_set", err_valid_drop, 1);
    check("drop_no_chg", err_payload_change, 0);
    repeat (3) tick();
    check("drop_flag_sticky", err_valid_drop, 1);

    // Upstream changes payload while stalled.
    do_reset();
    check("reset_clears_drop", err_valid_drop, 0);
    offer(32'h11, 5, cyc, acc);
    offer(32'h12, 5, cyc, acc);
    set_beat(32'h55);
    tick();
    set_beat(32'h56);
    tick();
    check("chg_flag_set", err_payload_change, 1);
    check("chg_no_drop", err_valid_drop, 0);

    // Reset with two beats buffered discards them immediately.
    arst_n = 0;
    s_if.tvalid = 0;
    #1;
    check("midrst_m_tvalid", m_if.tvalid, 0);
    check("midrst_s_tready", s_if.tready, 0);
    check("midrst_chg_clear", err_payload_change, 0);
    check("midrst_drop_clear", err_valid_drop, 0);
    tick();
    arst_n = 1;
    m_if.tready = 1;
    n0 = n_out;
    repeat (6) tick();
    check("midrst_no_stale", n_out - n0, 0);
    check("midrst_m_tvalid_after", m_if.tvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/axis_modport_slice.md
Name: axis_modport_slice

Overview:
- AXI-Stream register slice (two-entry skid buffer) between a receiver-modport `axis_if` and a transmitter-modport `axis_if`.
- Carries the full sideband (tdata, tstrb, tkeep, tlast, tid, tdest, twakeup) with 1-cycle latency at full throughput.
- All outputs are registered, which breaks both the valid/data and ready timing paths.
- Also runs a sticky protocol monitor on the upstream side to flag AXI-Stream handshake violations.

Parameters:
- TDATA_W, common_pkg::DEFAULT_TDATA_W, data width in bits; must be >0 and a multiple of 8.
- TID_W, common_pkg::DEFAULT_TID_W, tid width; must be >0.
- TDEST_W, common_pkg::DEFAULT_TDEST_W, tdest width; must be >0.
- Derived: TSTRB_W = TKEEP_W = TDATA_W/8.

Ports:
- aclk  input  1  clock; all state updates on its rising edge.
- arst_n  input  1  asynchronous active-low reset.
- s_axis  axis_if.receiver  TDATA_W/TID_W/TDEST_W  upstream stream; the slice drives s_axis.tready.
- m_axis  axis_if.transmitter  TDATA_W/TID_W/TDEST_W  downstream stream; the slice drives all transmitter fields.
- err_valid_drop  output  1  sticky: upstream tvalid fell before a handshake completed.
- err_payload_change  output  1  sticky: upstream payload changed while stalled.

Behaviour:
- Interface:
  - One clock; reset is asynchronous and active-low.
  - Clock is aclk, reset is arst_n, both shared with both axis_if instances.
- State:
  - Main register: m_axis fields plus m_axis.tvalid.
  - Skid register: a beat plus skid_valid.
  - s_axis.tready is a flop.
  - Beat = {tdata, tstrb, tkeep, tlast, tid, tdest, twakeup}.
- Reset (async assert):
  - m_axis.tvalid=0, skid_valid=0, s_axis.tready=0.
  - err_valid_drop=0, err_payload_change=0.
  - Data registers need no reset.
  - s_axis.tready rises to 1 on the first aclk edge after arst_n deasserts.
- Per edge, with s_fire = s.tvalid & s.tready and m_fire = m.tvalid & m.tready:
  - Main register empty, or m_fire: load it from skid if skid_valid (clearing skid), else from s_axis if s_fire, else clear m.tvalid.
  - Main register full and not m_fire, with s_fire: capture the beat in skid and set skid_valid.
  - s_axis.tready next = !(skid_valid_next).
- Ordering: strict FIFO, no beat lost or duplicated.
- Latency: a beat accepted at edge N is presented on m_axis after edge N (1 cycle).
- Throughput: 1 beat/cycle sustained when downstream tready is held high.
- Backpressure:
  - At most 2 beats are buffered.
  - tready drops the cycle after skid fills.
  - tready returns the cycle after the skid drains.
- Output stability: the m_axis payload is held stable while m.tvalid=1 and m.tready=0; m.tvalid never drops without m_fire.
- Monitor (active only when arst_n=1):
  - "Stalled" is recorded at an edge where s.tvalid=1 and s.tready=0.
  - At the next edge, s.tvalid=0 sets err_valid_drop.
  - At the next edge, s.tvalid=1 with a beat not equal to the recorded one sets err_payload_change.
  - Both flags are sticky until reset and do not affect the datapath.
- Mid-operation reset discards all buffered beats immediately.

Decomposition:
- common_pkg already holds the DEFAULT_TDATA_W, DEFAULT_TID_W and DEFAULT_TDEST_W constants; add nothing else to it.
- The beat packed struct depends on the parameters, so it is a module-local typedef.
- One sub-module: axis_proto_monitor (receiver-side sticky violation checker), reusable on any axis_if.

Test Plan:
- Reset, then stream 0x01..0x10 with m.tready=1 -> s.tready=1 from the first edge after reset; each beat appears 1 cycle later; 16 beats in 16 cycles.
- Hold m.tready=0, offer 0xA0, 0xA1, 0xA2 -> 0xA0 and 0xA1 are accepted; s.tready=0 after the 2nd acceptance; 0xA2 is held upstream.
- From that state, set m.tready=1 -> output order 0xA0, 0xA1, 0xA2; tlast/tid/tdest/twakeup/tstrb/tkeep match each beat.
- Random m.tready (50%) and random s.tvalid, 1000 beats -> scoreboard matches exactly; m payload stable while stalled.
- Stall upstream, then drop s.tvalid before tready -> err_valid_drop=1 and it stays 1; in a separate run, change tdata 0x55→0x56 while stalled -> err_payload_change=1.
- Assert arst_n low with 2 beats buffered -> m.tvalid=0 and s.tready=0 immediately, both error flags cleared; after release no stale beat is emitted.
